// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_pkg
// Description : Shared FSM state type, add-3 constants and pow10 helper for
//               the sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int ADD3_THRESH = 5;
  localparam int ADD3_VAL    = 3;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3_digit
// Description : Combinational conditional +3 on one 4-bit BCD scratch digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'(ADD3_THRESH)) begin
      o_digit = i_digit + 4'(ADD3_VAL);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative shift-and-add-3 binary-to-BCD converter with a
//               start/done handshake and registered, saturating outputs.
//               Optional leading-zero blanking when BIN2BCD_LZB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  // One guard digit above the output digits keeps wide inputs from wrapping.
  localparam int                   SCR_W   = 4*DIGITS + 4;
  localparam int                   CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam longint unsigned      OVF_THR = pow10(DIGITS);
  localparam logic [4*DIGITS-1:0]  SAT     = {DIGITS{4'h9}};

  state_e                state_q, state_d;
  logic [SCR_W-1:0]      scr_q, scr_d, scr_adj;
  logic [BIN_W-1:0]      shf_q, shf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   result;

  generate
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
      bcd_add3_digit u_add3 (
        .i_digit (scr_q[4*g +: 4]),
        .o_digit (scr_adj[4*g +: 4])
      );
    end
  endgenerate

  assign result = ovf_pend_q ? SAT : scr_q[4*DIGITS-1:0];

  always_comb begin
    state_d    = state_q;
    scr_d      = scr_q;
    shf_d      = shf_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    // Lags the state by one edge so it stays high through the done cycle.
    busy_d     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          shf_d      = bin;
          scr_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (64'(bin) >= OVF_THR);
        end
      end
      ST_SHIFT: begin
        {scr_d, shf_d} = {scr_adj, shf_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = result;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      scr_q      <= '0;
      shf_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      scr_q      <= scr_d;
      shf_q      <= shf_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

`ifdef BIN2BCD_LZB_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_run;

  // Digit 0 is never blanked so a zero value still shows a single 0.
  always_comb begin
    blank_d  = blank_q;
    zero_run = 1'b1;
    if (state_q == ST_DONE) begin
      blank_d = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_run   = zero_run & (result[4*i +: 4] == 4'd0);
        blank_d[i] = zero_run;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blank_q <= BLANK_RST;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule
`default_nettype wire
